shift_unit: RTL and testbench
=============================

// Module: shift_unit
// PURPOSE
//   Multi-cycle iterative shifter for the CPU execute stage: SLL/SRL/SRA and the
//   immediate forms SLLI/SRLI/SRAI. Trades latency for area versus a full barrel shifter.
//   Shifts up to STEP bits per cycle. Uses a valid/ready handshake toward the ALU
//   result mux, and a flush input for pipeline squash.
// PARAMETERS
//   XLEN  32  datapath width; power of 2, >= 8
//   STEP  1   max bits shifted per cycle; power of 2, 1..XLEN (STEP=XLEN => single pass)
// PORTS
//   clk           in   1         clock, rising edge
//   reset         in   1         asynchronous, active-high; clears all state
//   start_valid   in   1         request present
//   start_ready   out  1         request accepted when start_valid && start_ready
//   op            in   2         shift_op_t: SLL=2'b00, SRL=2'b01, SRA=2'b11 (2'b10 treated as SRL)
//   operand       in   XLEN      value to shift (rs1)
//   shamt         in   SHW       shift amount, SHW=$clog2(XLEN) (rs2[SHW-1:0] or imm)
//   flush         in   1         synchronous cancel of any in-flight op
//   result_valid  out  1         result available
//   result_ready  in   1         consumer accepts result
//   result        out  XLEN      shifted value
//   busy          out  1         state != IDLE
// BEHAVIOUR
//   Reset values: state=IDLE, result=0, result_valid=0, busy=0, start_ready=1.
//   FSM: IDLE -> SHIFT on accept with shamt!=0; IDLE -> DONE on accept with shamt==0.
//     SHIFT: per cycle, shift the data register by k=min(cnt,STEP) and set cnt-=k.
//       Go to DONE when cnt<=STEP.
//     DONE: result_valid=1 and result stable. Leave DONE when result_ready=1;
//       next state is IDLE, or SHIFT/DONE if a new request is accepted in the same cycle.
//   start_ready = (state==IDLE) || (state==DONE && result_ready); back-to-back ops need no bubble.
//   Latency (accept edge to result_valid high) = 1 + ceil(shamt/STEP) cycles; shamt=0 => 1.
//   Shift rules:
//     SLL fills zeros at LSB. SRL fills zeros at MSB.
//     SRA fills with operand[XLEN-1], captured at accept; sign stays constant across steps.
//     Only shamt[SHW-1:0] is honoured; upper bits are never presented.
//   Inputs op/operand/shamt are sampled only on the accept edge. Later changes are ignored.
//   flush=1 at an edge: state -> IDLE, result_valid -> 0, and no result is produced.
//     flush overrides start_valid in the same cycle (start_ready=0 while flush=1).
//     flush while in DONE drops the pending result, even if result_ready=1.
//   result_ready while not result_valid: ignored. start_valid while not start_ready: no effect.
//   Reset asserted mid-operation: immediate return to reset values; the op is lost
//     and no partial result is exposed.
//   result only updates inside the unit; the value in DONE equals the full shift, not an
//     intermediate one.
// STRUCTURE
//   riscv_pkg (shared): shift_op_t enum {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA}, and the
//     shift_state_t enum {SH_IDLE, SH_SHIFT, SH_DONE}; also used by the decoder/ALU.
//   Sub-module shift_step (combinational): data, op, sign, k (0..STEP) -> data shifted by k.
//     One instance per shift_unit.
//   Parent holds the FSM, the cnt register (SHW+1 bits), the data register, the sign bit,
//     and the handshake.
// TESTING (bench drives clk period 2, reset pulse at t=1)
//   1 STEP=1, SRL 0x00000002 by 1 -> result 0x00000001, valid 2 cycles after accept.
//   2 STEP=4, SRA 0x80000000 by 31 -> result 0xFFFFFFFF, valid 9 cycles after accept;
//     SRL same input -> 0x00000001.
//   3 STEP=1, SLL 0x00000001 by 0 -> 0x00000001 after 1 cycle. SLL 0x00000001 by 31
//     -> 0x80000000 after 32 cycles.
//   4 Backpressure: hold result_ready=0 for 5 cycles in DONE -> result_valid and result
//     stay stable and start_ready=0. Then raise result_ready together with a new start
//     -> both handshakes complete in the same cycle.
//   5 flush on the 3rd SHIFT cycle of SRL 0xFFFF0000 by 16 (STEP=1) -> IDLE next edge,
//     result_valid never asserted. flush+start_valid in the same cycle -> not accepted.
//   6 Assert reset mid-SHIFT -> busy=0, result=0, result_valid=0 immediately.
//     A fresh SRAI 0xF0000000 by 4 then gives 0xFF000000.

Source files
------------

// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared execute-stage types: shift operation encoding and the
//                iterative shifter state encoding, plus an op decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Shift operation encoding as presented by the decoder
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b11
    } shift_op_t;

    // Iterative shifter control states
    typedef enum logic [1:0] {
        SH_IDLE  = 2'b00,
        SH_SHIFT = 2'b01,
        SH_DONE  = 2'b10
    } shift_state_t;

    // Map the raw 2-bit op field onto a legal operation; the unused code 2'b10
    // behaves as a logical right shift.
    function automatic shift_op_t decode_shift_op(input logic [1:0] raw);
        shift_op_t op;
        case (raw)
            2'b00:   op = SHIFT_SLL;
            2'b11:   op = SHIFT_SRA;
            default: op = SHIFT_SRL;
        endcase
        return op;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/shift_unit_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-step shifter. Shifts i_data by i_k bits
//                (0..XLEN) left or right; arithmetic right shifts fill with the
//                captured sign bit rather than the current data MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int KW   = 6
) (
    input  logic [XLEN-1:0] i_data,
    input  shift_op_t       i_op,
    input  logic            i_sign,
    input  logic [KW-1:0]   i_k,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_fill;

    // Select the shift direction; the fill mask has ones in the top k bits
    always_comb begin
        w_fill = ~({XLEN{1'b1}} >> i_k);
        case (i_op)
            SHIFT_SLL: o_data = i_data << i_k;
            SHIFT_SRA: o_data = (i_data >> i_k) | (i_sign ? w_fill : {XLEN{1'b0}});
            default:   o_data = i_data >> i_k;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : shift_unit
//  Description : Multi-cycle iterative shifter (SLL/SRL/SRA) shifting up to
//                STEP bits per cycle, with valid/ready handshakes on both sides
//                and a synchronous flush for pipeline squash.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand,
    input  logic [SHW-1:0]  shamt,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    // The remaining-count register needs one extra bit so STEP=XLEN fits
    localparam int            CW     = SHW + 1;
    localparam logic [CW-1:0] C_STEP = CW'(STEP);

    shift_state_t    state_q,        state_d;
    shift_op_t       op_q,           op_d;
    logic            sign_q,         sign_d;
    logic [XLEN-1:0] data_q,         data_d;
    logic [CW-1:0]   cnt_q,          cnt_d;
    logic [XLEN-1:0] result_q,       result_d;
    logic            result_valid_q, result_valid_d;

    logic            w_start_ready;
    logic            w_accept;
    logic [CW-1:0]   w_k;
    logic [XLEN-1:0] w_step_data;

    // A new request can enter when idle, or when the pending result leaves this cycle
    assign w_start_ready = !flush &&
                           ((state_q == SH_IDLE) || ((state_q == SH_DONE) && result_ready));
    assign w_accept      = start_valid && w_start_ready;

    // Bits shifted this cycle: min(cnt, STEP)
    assign w_k = (cnt_q < C_STEP) ? cnt_q : C_STEP;

    shift_step #(
        .XLEN (XLEN),
        .KW   (CW)
    ) u_step (
        .i_data (data_q),
        .i_op   (op_q),
        .i_sign (sign_q),
        .i_k    (w_k),
        .o_data (w_step_data)
    );

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        sign_d         = sign_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        if (flush) begin
            // Squash: drop any in-flight or pending result
            state_d        = SH_IDLE;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                SH_IDLE: begin
                end
                SH_SHIFT: begin
                    data_d = w_step_data;
                    cnt_d  = cnt_q - w_k;
                    if (cnt_q <= C_STEP) begin
                        // Final step: publish the complete shift only
                        state_d        = SH_DONE;
                        result_d       = w_step_data;
                        result_valid_d = 1'b1;
                    end
                end
                SH_DONE: begin
                    if (result_ready) begin
                        state_d        = SH_IDLE;
                        result_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d        = SH_IDLE;
                    result_valid_d = 1'b0;
                end
            endcase

            // Accept overrides the IDLE/DONE transition above (back-to-back ops)
            if (w_accept) begin
                op_d   = decode_shift_op(op);
                sign_d = operand[XLEN-1];
                data_d = operand;
                cnt_d  = {1'b0, shamt};
                if (shamt == '0) begin
                    state_d        = SH_DONE;
                    result_d       = operand;
                    result_valid_d = 1'b1;
                end else begin
                    state_d        = SH_SHIFT;
                    result_valid_d = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SH_IDLE;
            op_q           <= SHIFT_SLL;
            sign_q         <= 1'b0;
            data_q         <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            sign_q         <= sign_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign start_ready  = w_start_ready;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign busy         = (state_q != SH_IDLE);

endmodule : shift_unit
`default_nettype wire

// File: tb/tb_shift_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit
//  Description : Directed self-checking bench for shift_unit, with one STEP=1
//                and one STEP=4 instance sharing clock, reset and data inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_unit;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        sv1          = 1'b0;
    logic        sv4          = 1'b0;
    logic [1:0]  op           = 2'b00;
    logic [31:0] operand      = 32'h0;
    logic [4:0]  shamt        = 5'h0;
    logic        flush        = 1'b0;
    logic        result_ready = 1'b1;

    logic        sr1, rv1, bz1;
    logic [31:0] res1;
    logic        sr4, rv4, bz4;
    logic [31:0] res4;

    bit          sel4 = 1'b0;
    logic        m_sr, m_rv, m_bz;
    logic [31:0] m_res;

    int checks   = 0;
    int failures = 0;

    shift_unit #(.XLEN(32), .STEP(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (sv1),
        .start_ready  (sr1),
        .op           (op),
        .operand      (operand),
        .shamt        (shamt),
        .flush        (flush),
        .result_valid (rv1),
        .result_ready (result_ready),
        .result       (res1),
        .busy         (bz1)
    );

    shift_unit #(.XLEN(32), .STEP(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (sv4),
        .start_ready  (sr4),
        .op           (op),
        .operand      (operand),
        .shamt        (shamt),
        .flush        (flush),
        .result_valid (rv4),
        .result_ready (result_ready),
        .result       (res4),
        .busy         (bz4)
    );

    assign m_sr  = sel4 ? sr4  : sr1;
    assign m_rv  = sel4 ? rv4  : rv1;
    assign m_bz  = sel4 ? bz4  : bz1;
    assign m_res = sel4 ? res4 : res1;

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel4) sv4 = v;
        else      sv1 = v;
    endtask

    // Issue one op on the selected unit, scramble inputs after accept, and
    // check latency (accept edge counts as cycle 1) and the final result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [4:0] s, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        op = o; operand = a; shamt = s; result_ready = 1'b1;
        set_start(1'b1);
        #0.2;
        chk({tag, "_start_ready"}, m_sr, 1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        op = ~o; operand = ~a; shamt = ~s;
        lat = 1;
        while (m_rv !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, m_res, exp);
    endtask

    initial begin
        int lat;
        int nv;
        int nb;

        #1 reset = 1'b1;
        #2.5;
        chk("rst_busy", bz1, 0);
        chk("rst_valid", rv1, 0);
        chk("rst_result", res1, 0);
        chk("rst_start_ready", sr1, 1);
        chk("rst_result4", res4, 0);
        #0.3 reset = 1'b0;

        // Basic operations, STEP=1
        run_op("srl1",    2'b01, 32'h0000_0002, 5'd1,  32'h0000_0001, 2);
        run_op("sll0",    2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, 1);
        run_op("sll31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
        run_op("sra4",    2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 5);
        run_op("op10srl", 2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000, 5);

        // STEP=4 instance
        sel4 = 1'b1;
        run_op("s4_sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
        run_op("s4_srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
        run_op("s4_sll5",  2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, 3);
        sel4 = 1'b0;

        // Backpressure in DONE, then simultaneous consume + new accept
        @(negedge clk);
        op = 2'b00; operand = 32'h3; shamt = 5'd2; result_ready = 1'b0; sv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0; operand = 32'hDEAD_BEEF; shamt = 5'd7;
        lat = 1;
        while (rv1 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", rv1, 1);
            chk("bp_result_hold", res1, 32'hC);
            chk("bp_start_ready_low", sr1, 0);
            @(negedge clk);
        end
        op = 2'b01; operand = 32'h80; shamt = 5'd3; sv1 = 1'b1; result_ready = 1'b1;
        #0.2;
        chk("b2b_start_ready", sr1, 1);
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0;
        chk("b2b_busy", bz1, 1);
        chk("b2b_valid_dropped", rv1, 0);
        lat = 1;
        while (rv1 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", lat, 4);
        chk("b2b_result", res1, 32'h10);

        // Flush on the third SHIFT cycle, with a competing start request
        @(negedge clk);
        op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd16; sv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; sv1 = 1'b1; op = 2'b00; operand = 32'h1; shamt = 5'd0;
        #0.2;
        chk("flush_start_ready", sr1, 0);
        @(negedge clk);
        flush = 1'b0; sv1 = 1'b0;
        chk("flush_busy", bz1, 0);
        chk("flush_valid", rv1, 0);
        nv = 0;
        nb = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rv1 === 1'b1) nv++;
            if (bz1 === 1'b1) nb++;
        end
        chk("flush_no_valid", nv, 0);
        chk("flush_no_busy", nb, 0);

        // Flush while a result is pending drops it even with result_ready high
        @(negedge clk);
        op = 2'b00; operand = 32'h5A; shamt = 5'd0; sv1 = 1'b1; result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0;
        chk("fdone_valid", rv1, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fdone_dropped", rv1, 0);
        chk("fdone_busy", bz1, 0);

        // Reset in the middle of a shift
        @(negedge clk);
        op = 2'b01; operand = 32'h1234_5678; shamt = 5'd10; sv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", bz1, 1);
        reset = 1'b1;
        #0.2;
        chk("mrst_busy", bz1, 0);
        chk("mrst_result", res1, 0);
        chk("mrst_valid", rv1, 0);
        chk("mrst_start_ready", sr1, 1);
        @(negedge clk);
        reset = 1'b0;
        run_op("srai4", 2'b11, 32'hF000_0000, 5'd4, 32'hFF00_0000, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_shift_unit
`default_nettype wire
